// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction memory port, IF/ID output register and redirect input.
// The master side belongs to pc_fetch; the slave side to the memory/decode environment.
interface pc_fetch_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   modport master (
      output imem_addr, if_valid, if_inst, if_pc, if_pc_plus4,
      input  imem_inst, if_ready, redirect_valid, redirect_target
   );

   modport slave (
      input  imem_addr, if_valid, if_inst, if_pc, if_pc_plus4,
      output imem_inst, if_ready, redirect_valid, redirect_target
   );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, IF/ID output register, redirect handling, fetch counter.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects into a sticky FAULT state.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   pc_fetch_if.master  bus,
   output logic [31:0] fetch_count,
   output logic        misalign_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
`else
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
`endif

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        capture, drain, take_redirect;
   logic [31:0] target_aligned;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        fault_hit;
   logic        fault_q;
`endif

   assign target_aligned   = {bus.redirect_target[31:2], 2'b00};
   assign bus.imem_addr    = pc;
   assign bus.if_valid     = out_valid;
   assign bus.if_inst      = out_inst;
   assign bus.if_pc        = out_pc;
   assign bus.if_pc_plus4  = out_pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Redirect outranks capture; IDLE only drains the output register on a handshake.
   always_comb begin
      state_nxt     = state;
      capture       = 1'b0;
      drain         = 1'b0;
      take_redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_hit     = 1'b0;
`endif
      case (state)
         IDLE, RUN: begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00))
               fault_hit = 1'b1;
            else
`endif
            if (bus.redirect_valid)
               take_redirect = 1'b1;
            else if (state == RUN)
               capture = !out_valid || bus.if_ready;
            else
               drain = out_valid && bus.if_ready;
            state_nxt = fetch_en ? RUN : IDLE;
`ifdef FETCH_ALIGN_CHECK_EN
            if (fault_hit) state_nxt = FAULT;
`endif
         end
`ifdef FETCH_ALIGN_CHECK_EN
         FAULT: state_nxt = FAULT;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         out_valid   <= 1'b0;
         out_inst    <= '0;
         out_pc      <= '0;
         fetch_count <= '0;
      end else begin
         if (take_redirect) begin
            pc        <= target_aligned;
            out_valid <= 1'b0;
         end else if (capture) begin
            out_inst  <= bus.imem_inst;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
         end else if (drain) begin
            out_valid <= 1'b0;
         end
`ifdef FETCH_ALIGN_CHECK_EN
         if (fault_hit) out_valid <= 1'b0;
`endif
         if (out_valid && bus.if_ready && !bus.redirect_valid)
            fetch_count <= fetch_count + 32'd1;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         fault_q <= 1'b0;
      else if (fault_hit) fault_q <= 1'b1;
   end
   assign misalign_fault = fault_q;
`else
   assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected IF/ID words are queued by the stimulus and
// popped by a negedge monitor on every completed handshake.
module tb_pc_fetch;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] fetch_count;
   logic        misalign_fault;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   pc_fetch_if intf ();

   // Memory returns the word index of the requested address.
   assign intf.imem_inst = {2'b00, intf.imem_addr[31:2]};

   pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .bus            (intf.master),
      .fetch_count    (fetch_count),
      .misalign_fault (misalign_fault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (rst_n && intf.if_valid && intf.if_ready && !intf.redirect_valid) begin
               if (sb.size() == 0) begin
                  check("sb_unexpected_pc", intf.if_pc, 32'hxxxx_xxxx);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("sb_if_pc", intf.if_pc, e.pc);
                  check("sb_if_inst", intf.if_inst, e.inst);
                  check("sb_if_pc_plus4", intf.if_pc_plus4, e.pc + 32'd4);
               end
            end
         end
      join_none

      rst_n = 1'b0;
      fetch_en = 1'b0;
      intf.if_ready = 1'b0;
      intf.redirect_valid = 1'b0;
      intf.redirect_target = '0;
      #3;
      check("rst_if_valid", {31'd0, intf.if_valid}, 32'd0);
      check("rst_if_inst", intf.if_inst, 32'd0);
      check("rst_if_pc", intf.if_pc, 32'd0);
      check("rst_if_pc_plus4", intf.if_pc_plus4, 32'd4);
      check("rst_fetch_count", fetch_count, 32'd0);
      check("rst_imem_addr", intf.imem_addr, 32'd0);
      check("rst_misalign", {31'd0, misalign_fault}, 32'd0);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      fetch_en = 1'b1;
      intf.if_ready = 1'b1;
      push(32'h0, 32'd0);
      push(32'h4, 32'd1);
      push(32'h8, 32'd2);
      push(32'hC, 32'd3);

      step();
      check("idle_to_run_no_capture", {31'd0, intf.if_valid}, 32'd0);
      step();
      check("first_fetch_valid", {31'd0, intf.if_valid}, 32'd1);
      check("first_fetch_pc", intf.if_pc, 32'h0);
      step();
      step();
      check("seq_if_pc", intf.if_pc, 32'h8);
      check("seq_count", fetch_count, 32'd2);

      intf.if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_if_pc", intf.if_pc, 32'h8);
         check("stall_if_inst", intf.if_inst, 32'd2);
         check("stall_imem_addr", intf.imem_addr, 32'hC);
         check("stall_count", fetch_count, 32'd2);
      end
      intf.if_ready = 1'b1;
      step();
      check("release_if_pc", intf.if_pc, 32'hC);
      step();
      check("count_after_4", fetch_count, 32'd4);
      check("seq_if_pc_10", intf.if_pc, 32'h10);

      intf.redirect_valid = 1'b1;
      intf.redirect_target = 32'h14;
      step();
      intf.redirect_valid = 1'b0;
      check("redir_bubble", {31'd0, intf.if_valid}, 32'd0);
      check("redir_count_hold", fetch_count, 32'd4);
      check("redir_imem_addr", intf.imem_addr, 32'h14);
      step();
      check("redir_target_pc", intf.if_pc, 32'h14);
      check("redir_target_inst", intf.if_inst, 32'd5);

      intf.redirect_valid = 1'b1;
      intf.redirect_target = 32'hFFFF_FFFC;
      step();
      intf.redirect_valid = 1'b0;
      check("stall_redir_drop", {31'd0, intf.if_valid}, 32'd0);
      check("stall_redir_count", fetch_count, 32'd4);
      push(32'hFFFF_FFFC, 32'h3FFF_FFFF);
      push(32'h0, 32'd0);
      step();
      check("wrap_if_pc", intf.if_pc, 32'hFFFF_FFFC);
      check("wrap_plus4", intf.if_pc_plus4, 32'h0);
      step();
      check("wrap_next_pc", intf.if_pc, 32'h0);
      check("wrap_count", fetch_count, 32'd5);

      @(negedge clk);
      #2;
      check("pre_areset_valid", {31'd0, intf.if_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("areset_valid", {31'd0, intf.if_valid}, 32'd0);
      check("areset_imem_addr", intf.imem_addr, 32'h0);
      check("areset_count", fetch_count, 32'd0);
      check("areset_plus4", intf.if_pc_plus4, 32'd4);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fetch_en = 1'b1;
      intf.if_ready = 1'b1;
      step();
      intf.redirect_valid = 1'b1;
      intf.redirect_target = 32'h6;
      step();
      intf.redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      check("misalign_flag", {31'd0, misalign_fault}, 32'd1);
      check("misalign_valid", {31'd0, intf.if_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("fault_valid_low", {31'd0, intf.if_valid}, 32'd0);
         check("fault_sticky", {31'd0, misalign_fault}, 32'd1);
         check("fault_pc_hold", intf.imem_addr, 32'h0);
         check("fault_count", fetch_count, 32'd0);
      end
      fetch_en = 1'b0;
`else
      check("misalign_flag_tied", {31'd0, misalign_fault}, 32'd0);
      check("misalign_bubble", {31'd0, intf.if_valid}, 32'd0);
      check("misalign_pc_masked", intf.imem_addr, 32'h4);
      push(32'h4, 32'd1);
      push(32'h8, 32'd2);
      step();
      check("misalign_if_pc", intf.if_pc, 32'h4);
      fetch_en = 1'b0;
      step();
      check("last_run_capture", intf.if_pc, 32'h8);
      step();
      check("idle_drain_valid", {31'd0, intf.if_valid}, 32'd0);
      check("idle_drain_count", fetch_count, 32'd2);
      step();
      check("idle_pc_hold", intf.imem_addr, 32'hC);
`endif

      step();
      check("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
